// File: rtl/driver_74hc165_if.sv
// driver_74hc165_if: bus between the 74HC165 scanner and its user/board
//   scan_en          user -> driver, keep scanning
//   SER_IN_0/1       board -> driver, QH of chain 0/1
//   SH_LD_N, SRCLK   driver -> board, 165 load/shift and clock
//   data_0/1, valid  driver -> user, committed frames and update strobe
interface driver_74hc165_if #(
  parameter int WIDTH = 32
);
  logic scan_en, SER_IN_0, SER_IN_1, SH_LD_N, SRCLK, valid;
  logic [WIDTH-1:0] data_0, data_1;
  modport master (input scan_en, SER_IN_0, SER_IN_1, output SH_LD_N, SRCLK, data_0, data_1, valid);
  modport slave (output scan_en, SER_IN_0, SER_IN_1, input SH_LD_N, SRCLK, data_0, data_1, valid);
endinterface

// File: rtl/driver_74hc165.sv
// driver_74hc165: continuous scanner for two daisy-chained 74HC165 chains
//   clk, resetn (async, active low); bus = driver_74hc165_if.master
//   optional DRIVER_74HC165_DEBOUNCE_EN: commit only two consecutive identical frames
module driver_74hc165 #(
  parameter int WIDTH = 32,
  parameter int CLK_DIV = 1
) (
  input logic clk,
  input logic resetn,
  driver_74hc165_if.master bus
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(WIDTH);
  typedef enum logic [2:0] {IDLE, LOAD, HOLD, SHIFT_LO, SHIFT_HI, DONE} state_t;
  state_t r_state;
  logic [DW-1:0] r_div;
  logic [BW-1:0] r_bit_cnt;
  logic r_sh_ld_n, r_srclk, r_valid;
  logic [WIDTH-2:0] r_sh0, r_sh1;
  logic [WIDTH-1:0] r_data0, r_data1;
  logic w_tick, w_last;
  logic [WIDTH-1:0] w_new0, w_new1;
`ifdef DRIVER_74HC165_DEBOUNCE_EN
  logic [WIDTH-1:0] r_prev0, r_prev1;
  logic r_primed;
`endif
  assign w_tick = r_div == DW'(CLK_DIV - 1);
  assign w_last = r_bit_cnt == BW'(WIDTH - 1);
  assign w_new0 = {r_sh0, bus.SER_IN_0};
  assign w_new1 = {r_sh1, bus.SER_IN_1};
  assign bus.SH_LD_N = r_sh_ld_n;
  assign bus.SRCLK = r_srclk;
  assign bus.data_0 = r_data0;
  assign bus.data_1 = r_data1;
  assign bus.valid = r_valid;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_div <= '0;
      r_bit_cnt <= '0;
      r_sh_ld_n <= 1'b1;
      r_srclk <= 1'b0;
      r_valid <= 1'b0;
      r_sh0 <= '0;
      r_sh1 <= '0;
      r_data0 <= '0;
      r_data1 <= '0;
`ifdef DRIVER_74HC165_DEBOUNCE_EN
      r_prev0 <= '0;
      r_prev1 <= '0;
      r_primed <= 1'b0;
`endif
    end else begin
      r_div <= w_tick ? '0 : r_div + 1'b1;
      r_valid <= 1'b0;
      if (w_tick) begin
        case (r_state)
          IDLE: if (bus.scan_en) begin
            r_state <= LOAD;
            r_sh_ld_n <= 1'b0;
          end
          LOAD: begin
            r_state <= HOLD;
            r_sh_ld_n <= 1'b1;
          end
          HOLD: r_state <= SHIFT_LO;
          SHIFT_LO: begin
            r_sh0 <= w_new0[WIDTH-2:0];
            r_sh1 <= w_new1[WIDTH-2:0];
            r_bit_cnt <= w_last ? '0 : r_bit_cnt + 1'b1;
            r_state <= w_last ? DONE : SHIFT_HI;
            r_srclk <= !w_last;
            if (w_last) begin
`ifdef DRIVER_74HC165_DEBOUNCE_EN
              // the first frame after reset only primes the history
              r_prev0 <= w_new0;
              r_prev1 <= w_new1;
              r_primed <= 1'b1;
              if (r_primed && w_new0 == r_prev0 && w_new1 == r_prev1) begin
                r_data0 <= w_new0;
                r_data1 <= w_new1;
                r_valid <= 1'b1;
              end
`else
              r_data0 <= w_new0;
              r_data1 <= w_new1;
              r_valid <= 1'b1;
`endif
            end
          end
          SHIFT_HI: begin
            r_state <= SHIFT_LO;
            r_srclk <= 1'b0;
          end
          DONE: begin
            r_bit_cnt <= '0;
            r_state <= bus.scan_en ? LOAD : IDLE;
            r_sh_ld_n <= !bus.scan_en;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_driver_74hc165.sv
// tb_driver_74hc165: directed bench with 74HC165 chain models, CLK_DIV=1 and CLK_DIV=3 instances
module tb_driver_74hc165;
`ifdef DRIVER_74HC165_DEBOUNCE_EN
  localparam int FIRST = 132;
`else
  localparam int FIRST = 66;
`endif
  localparam logic [31:0] P0 = 32'hA5C3_0F81;
  localparam logic [31:0] P1 = 32'h1234_5678;
  logic clk = 1'b0;
  logic resetn = 1'b1;
  logic [31:0] pa0 = P0, pa1 = P1;
  logic [31:0] sa0 = '0, sa1 = '0, sb0 = '0, sb1 = '0;
  int n_cmp = 0, n_err = 0, n, h, k;
  driver_74hc165_if #(.WIDTH(32)) if_a ();
  driver_74hc165_if #(.WIDTH(32)) if_b ();
  driver_74hc165 #(.WIDTH(32), .CLK_DIV(1)) dut_a (.clk(clk), .resetn(resetn), .bus(if_a));
  driver_74hc165 #(.WIDTH(32), .CLK_DIV(3)) dut_b (.clk(clk), .resetn(resetn), .bus(if_b));
  always #5 clk = ~clk;
  always @(posedge if_a.SRCLK or negedge if_a.SH_LD_N)
    if (!if_a.SH_LD_N) begin
      sa0 <= pa0;
      sa1 <= pa1;
    end else begin
      sa0 <= sa0 << 1;
      sa1 <= sa1 << 1;
    end
  always @(posedge if_b.SRCLK or negedge if_b.SH_LD_N)
    if (!if_b.SH_LD_N) begin
      sb0 <= P0;
      sb1 <= P1;
    end else begin
      sb0 <= sb0 << 1;
      sb1 <= sb1 << 1;
    end
  assign if_a.SER_IN_0 = sa0[31];
  assign if_a.SER_IN_1 = sa1[31];
  assign if_b.SER_IN_0 = sb0[31];
  assign if_b.SER_IN_1 = sb1[31];
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic wait_valid(input bit b, output int cnt);
    cnt = 0;
    do begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
    end while (!(b ? if_b.valid : if_a.valid) && cnt < 2000);
  endtask
  initial begin
    if_a.scan_en = 1'b1;
    if_b.scan_en = 1'b1;
    #1 resetn = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("rst_ctl", {if_a.SH_LD_N, if_a.SRCLK, if_a.valid}, 3'b100);
    end
    chk("rst_d0", if_a.data_0, 0);
    chk("rst_d1", if_a.data_1, 0);
    resetn = 1'b1;
    wait_valid(0, n);
    chk("first_lat", n, FIRST);
    chk("first_d0", if_a.data_0, P0);
    chk("first_d1", if_a.data_1, P1);
    wait_valid(0, n);
    chk("period", n, 66);
    chk("rep_d0", if_a.data_0, P0);
    @(posedge clk);
    @(negedge clk);
    chk("valid_pulse", if_a.valid, 0);
    wait_valid(1, n);
    wait_valid(1, n);
    chk("div3_period", n, 198);
    chk("div3_d0", if_b.data_0, P0);
    chk("div3_d1", if_b.data_1, P1);
    k = 0;
    while (!if_b.SRCLK && k < 100) begin
      @(negedge clk);
      k++;
    end
    h = 0;
    while (if_b.SRCLK && h < 100) begin
      @(negedge clk);
      h++;
    end
    chk("div3_srclk_hi", h, 3);
    wait_valid(0, n);
    repeat (23) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("bit10_srclk", {if_a.SH_LD_N, if_a.SRCLK}, 2'b10);
    if_a.scan_en = 1'b0;
    wait_valid(0, n);
    chk("stop_lat", n, 43);
    chk("stop_d0", if_a.data_0, P0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("idle_ctl", {if_a.SH_LD_N, if_a.SRCLK, if_a.valid}, 3'b100);
    end
    chk("idle_d1", if_a.data_1, P1);
    if_a.scan_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("restart_load", if_a.SH_LD_N, 0);
    wait_valid(0, n);
    chk("restart_lat", n, 65);
    chk("restart_d0", if_a.data_0, P0);
    repeat (43) begin
      @(posedge clk);
      @(negedge clk);
    end
    resetn = 1'b0;
    #1;
    chk("abort_ctl", {if_a.SH_LD_N, if_a.SRCLK, if_a.valid}, 3'b100);
    chk("abort_d0", if_a.data_0, 0);
    chk("abort_d1", if_a.data_1, 0);
    repeat (3) @(negedge clk);
    chk("abort_valid", if_a.valid, 0);
    resetn = 1'b1;
    wait_valid(0, n);
    chk("post_rst_lat", n, FIRST);
    chk("post_rst_d0", if_a.data_0, P0);
    chk("post_rst_d1", if_a.data_1, P1);
`ifdef DRIVER_74HC165_DEBOUNCE_EN
    pa0 = 32'h0;
    wait_valid(0, n);
    chk("db_zero_lat", n, 132);
    chk("db_zero_d0", if_a.data_0, 0);
    pa0 = 32'h1;
    @(posedge clk);
    @(negedge clk);
    pa0 = 32'h0;
    wait_valid(0, n);
    chk("db_glitch_lat", n, 197);
    chk("db_glitch_d0", if_a.data_0, 0);
    pa0 = 32'h1;
    wait_valid(0, n);
    chk("db_hold_lat", n, 132);
    chk("db_hold_d0", if_a.data_0, 1);
    chk("db_hold_d1", if_a.data_1, P1);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
